// File: rtl/cpu_debug_tx_if.sv
// Halt/snapshot inputs and UART/status outputs of the CPU debug transmitter.
// The master drives the CPU side; the slave is the transmitter itself.
interface cpu_debug_tx_if;
   logic        i_halt;
   logic [10:0] i_pc;
   logic [15:0] i_acc;
   logic [15:0] i_inst;
   logic        o_tx;
   logic        o_busy;
   logic        o_done;

   modport master (
      output i_halt, i_pc, i_acc, i_inst,
      input  o_tx, o_busy, o_done
   );

   modport slave (
      input  i_halt, i_pc, i_acc, i_inst,
      output o_tx, o_busy, o_done
   );
endinterface

// File: rtl/cpu_debug_tx.sv
// On a rising edge of halt, snapshots PC/ACC/INST and streams them as 8N1 UART bytes
// after a header byte. Define DBG_CHECKSUM_EN to append an XOR checksum byte.
module cpu_debug_tx #(
   parameter int          CLKS_PER_BIT = 5208,
   parameter logic [7:0]  HEADER       = 8'hA5
) (
   input  logic         i_clk,
   input  logic         i_rst,
   cpu_debug_tx_if.slave dbg
);

`ifdef DBG_CHECKSUM_EN
   localparam int NBYTES = 8;
`else
   localparam int NBYTES = 7;
`endif
   localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_BYTE = 3'(NBYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [2:0]       byte_idx_q, byte_idx_d;
   logic             halt_q;
   logic [10:0]      pc_q;
   logic [15:0]      acc_q;
   logic [15:0]      inst_q;

   logic             halt_edge;
   logic             bit_done;
   logic             capture;
   logic [7:0]       cur_byte;
   logic             tx;
   logic             busy;
   logic             done;

   assign halt_edge = dbg.i_halt & ~halt_q;
   assign bit_done  = (clk_cnt_q == CNT_LAST);

   always_comb begin
      cur_byte = HEADER;
      case (byte_idx_q)
         3'd0:    cur_byte = HEADER;
         3'd1:    cur_byte = {5'b0, pc_q[10:8]};
         3'd2:    cur_byte = pc_q[7:0];
         3'd3:    cur_byte = acc_q[15:8];
         3'd4:    cur_byte = acc_q[7:0];
         3'd5:    cur_byte = inst_q[15:8];
         3'd6:    cur_byte = inst_q[7:0];
`ifdef DBG_CHECKSUM_EN
         3'd7:    cur_byte = {5'b0, pc_q[10:8]} ^ pc_q[7:0] ^ acc_q[15:8] ^ acc_q[7:0]
                           ^ inst_q[15:8] ^ inst_q[7:0];
`endif
         default: cur_byte = HEADER;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q    <= S_IDLE;
         clk_cnt_q  <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         halt_q     <= 1'b0;
         pc_q       <= '0;
         acc_q      <= '0;
         inst_q     <= '0;
      end else begin
         state_q    <= state_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         // Sampled every cycle so an edge seen outside IDLE is consumed, never queued.
         halt_q     <= dbg.i_halt;
         if (capture) begin
            pc_q   <= dbg.i_pc;
            acc_q  <= dbg.i_acc;
            inst_q <= dbg.i_inst;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      capture    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (halt_edge) begin
               state_d    = S_START;
               capture    = 1'b1;
               clk_cnt_d  = '0;
               bit_idx_d  = '0;
               byte_idx_d = '0;
            end
         end
         S_START: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               if (byte_idx_q == LAST_BYTE) begin
                  state_d = S_DONE;
               end else begin
                  byte_idx_d = byte_idx_q + 3'd1;
                  state_d    = S_START;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode straight from state so reset forces the idle line level instantly.
   always_comb begin
      tx   = 1'b1;
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_START: begin
            tx   = 1'b0;
            busy = 1'b1;
         end
         S_DATA: begin
            tx   = cur_byte[bit_idx_q];
            busy = 1'b1;
         end
         S_STOP:  busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: begin
            tx   = 1'b1;
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   assign dbg.o_tx   = tx;
   assign dbg.o_busy = busy;
   assign dbg.o_done = done;

endmodule

// File: tb/tb_cpu_debug_tx.sv
// Self-checking bench for cpu_debug_tx: per-cycle line waveform predicted from the
// packet byte list, plus mid-bit decoding of each transmitted packet.
module tb_cpu_debug_tx;
   localparam int CPB = 4;
`ifdef DBG_CHECKSUM_EN
   localparam int NB = 8;
`else
   localparam int NB = 7;
`endif
   localparam int FRAME = 10 * CPB;
   localparam int PKT   = NB * FRAME;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;

   cpu_debug_tx_if dbg ();

   cpu_debug_tx #(
      .CLKS_PER_BIT (CPB),
      .HEADER       (8'hA5)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .dbg   (dbg)
   );

   always #5 i_clk = ~i_clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         pkt_no   = 0;
   logic [7:0] exp_bytes [8];
   logic [7:0] rx_bytes  [8];

   // Reference packet: header, PC high/low, ACC high/low, INST high/low, XOR of bytes 1..6.
   task automatic model_bytes(input logic [10:0] pc, input logic [15:0] acc, input logic [15:0] inst);
      exp_bytes[0] = 8'hA5;
      exp_bytes[1] = {5'b0, pc[10:8]};
      exp_bytes[2] = pc[7:0];
      exp_bytes[3] = acc[15:8];
      exp_bytes[4] = acc[7:0];
      exp_bytes[5] = inst[15:8];
      exp_bytes[6] = inst[7:0];
      exp_bytes[7] = 8'h00;
      for (int i = 1; i <= 6; i++) exp_bytes[7] = exp_bytes[7] ^ exp_bytes[i];
   endtask

   // Line level k cycles after the capture edge (k = 1 is the first start-bit cycle).
   function automatic logic exp_tx(input int k);
      int idx, b, pos;
      idx = k - 1;
      if (idx >= PKT) return 1'b1;
      b   = idx / FRAME;
      pos = (idx % FRAME) / CPB;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return exp_bytes[b][pos-1];
   endfunction

   task automatic fire(input logic [10:0] pc, input logic [15:0] acc, input logic [15:0] inst);
      dbg.i_halt = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      dbg.i_pc   = pc;
      dbg.i_acc  = acc;
      dbg.i_inst = inst;
      dbg.i_halt = 1'b1;
      model_bytes(pc, acc, inst);
      @(posedge i_clk);
   endtask

   // Walks cycles 1..last_k after the capture edge; scramble 1 = all ones, 2 = random.
   task automatic run_packet(input string name, input int scramble, input bit reedge, input int last_k);
      string s;
      for (int i = 0; i < 8; i++) rx_bytes[i] = 8'h00;
      for (int k = 1; k <= last_k; k++) begin
         int pos, ph, b;
         @(negedge i_clk);
         n_checks++;
         if (dbg.o_tx !== exp_tx(k)) begin
            n_errors++;
            $display("FAIL %s tx cycle %0d: got %b expected %b", name, k, dbg.o_tx, exp_tx(k));
         end
         n_checks++;
         if (dbg.o_busy !== (k <= PKT)) begin
            n_errors++;
            $display("FAIL %s busy cycle %0d: got %b expected %b", name, k, dbg.o_busy, (k <= PKT));
         end
         n_checks++;
         if (dbg.o_done !== (k == PKT + 1)) begin
            n_errors++;
            $display("FAIL %s done cycle %0d: got %b expected %b", name, k, dbg.o_done, (k == PKT + 1));
         end
         if (k <= PKT) begin
            b   = (k - 1) / FRAME;
            pos = ((k - 1) % FRAME) / CPB;
            ph  = (k - 1) % CPB;
            if (ph == CPB / 2 && pos >= 1 && pos <= 8) rx_bytes[b][pos-1] = dbg.o_tx;
         end
         if (k == 1 && scramble == 1) begin
            dbg.i_pc = 11'h7FF; dbg.i_acc = 16'hFFFF; dbg.i_inst = 16'hFFFF;
         end else if (k == 1 && scramble == 2) begin
            dbg.i_pc = 11'($urandom); dbg.i_acc = 16'($urandom); dbg.i_inst = 16'($urandom);
         end
         if (reedge && k == 98) dbg.i_halt = 1'b0;
         if (reedge && k == 99) dbg.i_halt = 1'b1;
      end
      if (last_k > PKT) begin
         s = "";
         for (int i = 0; i < NB; i++) begin
            s = {s, $sformatf(" %h", rx_bytes[i])};
            n_checks++;
            if (rx_bytes[i] !== exp_bytes[i]) begin
               n_errors++;
               $display("FAIL %s byte %0d: got %h expected %h", name, i, rx_bytes[i], exp_bytes[i]);
            end
         end
         pkt_no++;
         $display("packet %0d (%s):%s", pkt_no, name, s);
      end
   endtask

   task automatic check_idle(input string name, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         @(negedge i_clk);
         n_checks++;
         if (dbg.o_tx !== 1'b1 || dbg.o_busy !== 1'b0 || dbg.o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s idle cycle %0d: got tx/busy/done %b%b%b expected 100",
                     name, k, dbg.o_tx, dbg.o_busy, dbg.o_done);
         end
      end
   endtask

   task automatic test_reset();
      dbg.i_halt = 1'b0; dbg.i_pc = '0; dbg.i_acc = '0; dbg.i_inst = '0;
      #1 i_rst = 1'b0;
      #1;
      n_checks++;
      if (dbg.o_tx !== 1'b1 || dbg.o_busy !== 1'b0 || dbg.o_done !== 1'b0) begin
         n_errors++;
         $display("FAIL reset outputs: got tx/busy/done %b%b%b expected 100", dbg.o_tx, dbg.o_busy, dbg.o_done);
      end
      repeat (3) @(negedge i_clk);
      i_rst = 1'b1;
      check_idle("reset_idle", 100);
      $display("reset: 100 idle cycles observed");
   endtask

   task automatic test_packet();
      fire(11'h005, 16'h1234, 16'h0805);
      run_packet("fixed_scrambled", 1, 1'b0, PKT + 1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++) begin
         fire(11'($urandom), 16'($urandom), 16'($urandom));
         run_packet("random", 2, 1'b0, PKT + 1);
      end
   endtask

   task automatic test_ignore_edge();
      fire(11'($urandom), 16'($urandom), 16'($urandom));
      run_packet("second_edge", 0, 1'b1, PKT + 1);
      check_idle("held_high", 60);
   endtask

   task automatic test_reset_mid();
      logic [10:0] pc;
      logic [15:0] acc, inst;
      fire(11'($urandom), 16'($urandom), 16'($urandom));
      run_packet("aborted", 0, 1'b0, 60);
      #2 i_rst = 1'b0;
      #1;
      n_checks++;
      if (dbg.o_tx !== 1'b1 || dbg.o_busy !== 1'b0 || dbg.o_done !== 1'b0) begin
         n_errors++;
         $display("FAIL async_reset: got tx/busy/done %b%b%b expected 100", dbg.o_tx, dbg.o_busy, dbg.o_done);
      end
      pc = 11'($urandom); acc = 16'($urandom); inst = 16'($urandom);
      dbg.i_pc = pc; dbg.i_acc = acc; dbg.i_inst = inst;
      check_idle("in_reset", 2);
      #1 i_rst = 1'b1;
      model_bytes(pc, acc, inst);
      @(posedge i_clk);
      run_packet("after_reset", 0, 1'b0, PKT + 1);
   endtask

   initial begin
      test_reset();
      test_packet();
      test_random();
      test_ignore_edge();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
